// File: rtl/xalu_pkg.sv
// Shared op codes, FSM state encoding and helpers for the XALU multiply/divide sequencer.
// Op codes are 4 bits wide and match the execute-stage E_XALU_Op field.
package xalu_pkg;

    localparam logic [3:0] XOP_NONE  = 4'd0;
    localparam logic [3:0] XOP_MULT  = 4'd1;
    localparam logic [3:0] XOP_MULTU = 4'd2;
    localparam logic [3:0] XOP_DIV   = 4'd3;
    localparam logic [3:0] XOP_DIVU  = 4'd4;
    localparam logic [3:0] XOP_MTHI  = 4'd5;
    localparam logic [3:0] XOP_MTLO  = 4'd6;
    localparam logic [3:0] XOP_MADD  = 4'd7;
    localparam logic [3:0] XOP_MADDU = 4'd8;
    localparam logic [3:0] XOP_MSUB  = 4'd9;
    localparam logic [3:0] XOP_MSUBU = 4'd10;

    localparam int XALU_DIV_STEPS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } xalu_state_e;

    // Magnitude of a 32-bit operand; 0x80000000 maps onto itself as an unsigned value.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Restoring radix-2 shift-subtract divider on unsigned magnitudes.
// Latency: result valid 32 cycles after the start cycle, then held until the next start.
// Backpressure: none; start is only pulsed by the controller while it is idle.
module div_radix2
    import xalu_pkg::*;
(
    input  logic        Clk,
    input  logic        Clr,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] q_q;
    logic [31:0] r_q;
    logic [31:0] d_q;
    logic [5:0]  step_q;
    logic        run_q;

    logic [32:0] part;
    logic        take;
    logic [31:0] diff;

    // A zero divisor always "takes", giving an all-ones quotient and remainder = dividend.
    always_comb begin
        part = {r_q, q_q[31]};
        take = (part >= {1'b0, d_q});
        diff = part[31:0] - d_q;
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else if (start) begin
            q_q    <= dividend;
            r_q    <= '0;
            d_q    <= divisor;
            step_q <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            q_q    <= {q_q[30:0], take};
            r_q    <= take ? diff : part[31:0];
            step_q <= step_q + 6'd1;
            if (step_q == 6'(XALU_DIV_STEPS - 1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;

endmodule

// File: rtl/xalu_ctrl.sv
// XALU sequencer owning HI/LO: pipelined multiply, 32-step divide, MTHI/MTLO; MADD family under XALU_MADD_EN.
// Latency: MTHI/MTLO 1 cycle, multiply MUL_LAT+1 cycles, divide 34 cycles to HI/LO update.
// Backpressure: registered E_XALU_Busy while in flight; starts are dropped unless idle and not stalled/flushed.
module xalu_ctrl
    import xalu_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        dm_stall,
    input  logic        exp_flush,
    input  logic        E_XALU_Start,
    input  logic [3:0]  E_XALU_Op,
    input  logic [31:0] E_RsData,
    input  logic [31:0] E_RtData,
    output logic        E_XALU_Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int PIPE_N = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

    xalu_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q;

    logic [31:0] mul_a_q, mul_b_q;
    logic        mul_sgn_q;
    logic        div_qneg_q, div_rneg_q;

    logic op_mul, op_div, op_sgn, op_mthi, op_mtlo;
    logic accept, mul_load, div_start;
`ifdef XALU_MADD_EN
    logic op_acc, op_sub;
    logic mul_acc_q, mul_sub_q;
`endif

    always_comb begin
        op_mul  = 1'b0;
        op_div  = 1'b0;
        op_sgn  = 1'b0;
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
`ifdef XALU_MADD_EN
        op_acc  = 1'b0;
        op_sub  = 1'b0;
`endif
        case (E_XALU_Op)
            XOP_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
            XOP_MULTU: op_mul = 1'b1;
            XOP_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
            XOP_DIVU:  op_div = 1'b1;
            XOP_MTHI:  op_mthi = 1'b1;
            XOP_MTLO:  op_mtlo = 1'b1;
`ifdef XALU_MADD_EN
            XOP_MADD:  begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; end
            XOP_MADDU: begin op_mul = 1'b1; op_acc = 1'b1; end
            XOP_MSUB:  begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
            XOP_MSUBU: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign accept = E_XALU_Start & ~dm_stall & ~exp_flush & (state_q == IDLE);

    // Multiply: operands registered at accept, product retimed through MUL_LAT-1 stages.
    logic [63:0] mul_ax, mul_bx, prod_c, mul_res, mul_wb;
    logic [63:0] prod_pipe [PIPE_N];

    assign mul_ax = {{32{mul_sgn_q & mul_a_q[31]}}, mul_a_q};
    assign mul_bx = {{32{mul_sgn_q & mul_b_q[31]}}, mul_b_q};
    assign prod_c = mul_ax * mul_bx;

    always_ff @(posedge Clk) begin
        prod_pipe[0] <= prod_c;
        for (int i = 1; i < PIPE_N; i++) begin
            prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    generate
        if (MUL_LAT == 1) begin : g_mul_comb
            assign mul_res = prod_c;
        end else begin : g_mul_pipe
            assign mul_res = prod_pipe[PIPE_N-1];
        end
    endgenerate

`ifdef XALU_MADD_EN
    always_comb begin
        mul_wb = mul_res;
        if (mul_acc_q) begin
            mul_wb = mul_sub_q ? ({hi_q, lo_q} - mul_res) : ({hi_q, lo_q} + mul_res);
        end
    end
`else
    assign mul_wb = mul_res;
`endif

    logic [31:0] div_quo, div_rem;

    div_radix2 u_div (
        .Clk       (Clk),
        .Clr       (Clr),
        .start     (div_start),
        .dividend  (mag32(E_RsData, op_sgn)),
        .divisor   (mag32(E_RtData, op_sgn)),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_load  = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_mul) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        mul_load = 1'b1;
                    end else if (op_div) begin
                        state_d   = DIV;
                        cnt_d     = '0;
                        div_start = 1'b1;
                    end else if (op_mthi) begin
                        hi_d = E_RsData;
                    end else if (op_mtlo) begin
                        lo_d = E_RsData;
                    end
                end
            end
            MUL: begin
                if (cnt_q == 5'(MUL_LAT - 1)) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    {hi_d, lo_d} = mul_wb;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DIV: begin
                if (cnt_q == 5'(XALU_DIV_STEPS - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            FIX: begin
                state_d = IDLE;
                lo_d    = div_qneg_q ? (~div_quo + 32'd1) : div_quo;
                hi_d    = div_rneg_q ? (~div_rem + 32'd1) : div_rem;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_sgn_q  <= 1'b0;
            div_qneg_q <= 1'b0;
            div_rneg_q <= 1'b0;
`ifdef XALU_MADD_EN
            mul_acc_q  <= 1'b0;
            mul_sub_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != IDLE);
            if (mul_load) begin
                mul_a_q   <= E_RsData;
                mul_b_q   <= E_RtData;
                mul_sgn_q <= op_sgn;
`ifdef XALU_MADD_EN
                mul_acc_q <= op_acc;
                mul_sub_q <= op_sub;
`endif
            end
            if (div_start) begin
                div_qneg_q <= op_sgn & (E_RsData[31] ^ E_RtData[31]);
                div_rneg_q <= op_sgn & E_RsData[31];
            end
        end
    end

    assign E_XALU_Busy = busy_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule

// File: tb/tb_xalu_ctrl.sv
// Randomized scoreboard bench for xalu_ctrl; reference model uses plain 64-bit arithmetic.
// Build with +define+XALU_MADD_EN to exercise the multiply-accumulate ops.
module tb_xalu_ctrl;
    import xalu_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = XALU_DIV_STEPS + 1;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        dm_stall = 1'b0;
    logic        exp_flush = 1'b0;
    logic        E_XALU_Start = 1'b0;
    logic [3:0]  E_XALU_Op = 4'd0;
    logic [31:0] E_RsData = '0;
    logic [31:0] E_RtData = '0;
    logic        E_XALU_Busy;
    logic [31:0] HI, LO;

    xalu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .Clk          (Clk),
        .Clr          (Clr),
        .dm_stall     (dm_stall),
        .exp_flush    (exp_flush),
        .E_XALU_Start (E_XALU_Start),
        .E_XALU_Op    (E_XALU_Op),
        .E_RsData     (E_RsData),
        .E_RtData     (E_RtData),
        .E_XALU_Busy  (E_XALU_Busy),
        .HI           (HI),
        .LO           (LO)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    bit          exp_busy [0:65535];
    int          mon_from = 1 << 30;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] cur_hi = '0, cur_lo = '0;

    function automatic bit legal(input logic [3:0] op);
`ifdef XALU_MADD_EN
        return (op >= XOP_MULT) && (op <= XOP_MSUBU);
`else
        return (op >= XOP_MULT) && (op <= XOP_MTLO);
`endif
    endfunction

    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        if (sgn) begin sa = int'(a); sb2 = int'(b); end
        else begin sa = longint'(a); sb2 = longint'(b); end
        return sa * sb2;
    endfunction

    // Returns {remainder, quotient}.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2, ma, mb, q, r;
        bit an, bn;
        if (sgn) begin sa = int'(a); sb2 = int'(b); end
        else begin sa = longint'(a); sb2 = longint'(b); end
        an = (sa < 0);
        bn = (sb2 < 0);
        ma = an ? -sa : sa;
        mb = bn ? -sb2 : sb2;
        if (mb == 0) begin
            q = 64'h0000_0000_FFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (an != bn) q = -q;
        if (an) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input int lat);
        exp_t e;
        for (int i = 1; i <= lat; i++) exp_busy[cyc+i] = 1'b1;
        e.due = cyc + 1 + lat;
        e.hi  = m_hi;
        e.lo  = m_lo;
        sb.push_back(e);
    endtask

    task automatic do_clr();
        exp_t e;
        Clr = 1'b1;
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        for (int i = cyc + 1; i <= cyc + 40; i++) exp_busy[i] = 1'b0;
        m_hi = '0;
        m_lo = '0;
        e.due = cyc + 1;
        e.hi  = '0;
        e.lo  = '0;
        sb.push_back(e);
        if (mon_from > cyc + 1) mon_from = cyc + 1;
        tick();
        Clr = 1'b0;
    endtask

    // One cycle of start; the model decides whether the next edge accepts it.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit stall, input bit flush);
        logic [63:0] r;
        E_XALU_Start = 1'b1;
        E_XALU_Op    = op;
        E_RsData     = a;
        E_RtData     = b;
        dm_stall     = stall;
        exp_flush    = flush;
        if (!stall && !flush && !exp_busy[cyc] && legal(op)) begin
            case (op)
                XOP_MTHI:  begin m_hi = a; push_exp(0); end
                XOP_MTLO:  begin m_lo = a; push_exp(0); end
                XOP_MULT:  begin {m_hi, m_lo} = ref_mul(1'b1, a, b); push_exp(MUL_LAT); end
                XOP_MULTU: begin {m_hi, m_lo} = ref_mul(1'b0, a, b); push_exp(MUL_LAT); end
                XOP_DIV:   begin r = ref_div(1'b1, a, b); {m_hi, m_lo} = r; push_exp(DIV_LAT); end
                XOP_DIVU:  begin r = ref_div(1'b0, a, b); {m_hi, m_lo} = r; push_exp(DIV_LAT); end
                XOP_MADD:  begin {m_hi, m_lo} = {m_hi, m_lo} + ref_mul(1'b1, a, b); push_exp(MUL_LAT); end
                XOP_MADDU: begin {m_hi, m_lo} = {m_hi, m_lo} + ref_mul(1'b0, a, b); push_exp(MUL_LAT); end
                XOP_MSUB:  begin {m_hi, m_lo} = {m_hi, m_lo} - ref_mul(1'b1, a, b); push_exp(MUL_LAT); end
                XOP_MSUBU: begin {m_hi, m_lo} = {m_hi, m_lo} - ref_mul(1'b0, a, b); push_exp(MUL_LAT); end
                default: ;
            endcase
        end
        tick();
        E_XALU_Start = 1'b0;
        dm_stall     = 1'b0;
        exp_flush    = 1'b0;
        E_XALU_Op    = 4'($urandom_range(0, 15));
        E_RsData     = $urandom;
        E_RtData     = $urandom;
    endtask

    task automatic wait_idle();
        while (exp_busy[cyc]) tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: busy every cycle; HI/LO take the scoreboard value when due, else must hold.
    always @(negedge Clk) begin
        exp_t e;
        if (cyc >= mon_from) begin
            checks++;
            if (E_XALU_Busy !== exp_busy[cyc]) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, E_XALU_Busy, exp_busy[cyc]);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                cur_hi = e.hi;
                cur_lo = e.lo;
            end
            checks++;
            if (HI !== cur_hi || LO !== cur_lo) begin
                errors++;
                $display("FAIL hilo cyc=%0d got HI=%h LO=%h exp HI=%h LO=%h", cyc, HI, LO, cur_hi, cur_lo);
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        tick();
        do_clr();
        do_clr();
        repeat (2) tick();

        drive(XOP_MULT,  32'hFFFF_FFFF, 32'd2, 0, 0); wait_idle();
        drive(XOP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0); wait_idle();
        drive(XOP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0); wait_idle();
        drive(XOP_DIVU,  32'd5, 32'd0, 0, 0); wait_idle();
        drive(XOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0); wait_idle();
        drive(XOP_DIV,   32'hFFFF_FFF9, 32'd0, 0, 0); wait_idle();

        // Held start: stalled, then accepted once, then ignored while busy.
        repeat (4) drive(XOP_MULT, 32'd3, 32'd5, 1, 0);
        repeat (3) drive(XOP_MULT, 32'd3, 32'd5, 0, 0);
        wait_idle();

        drive(XOP_MTLO, 32'hDEAD_BEEF, 32'd0, 0, 1);
        drive(XOP_MULT, 32'd7, 32'd9, 0, 1);
        repeat (3) tick();

        drive(XOP_DIV, 32'd1000, 32'd7, 0, 0);
        repeat (10) tick();
        do_clr();
        drive(XOP_MTLO, 32'h0000_1234, 32'd0, 0, 0);
        repeat (2) tick();

        drive(XOP_MTHI, 32'd1, 32'd0, 0, 0);
        drive(XOP_MTLO, 32'hFFFF_FFFF, 32'd0, 0, 0);
        drive(XOP_MADDU, 32'd1, 32'd1, 0, 0); wait_idle();
        drive(XOP_MSUB, 32'hFFFF_FFFF, 32'd3, 0, 0); wait_idle();
        drive(XOP_MULT, 32'd6, 32'd7, 0, 0);
        drive(XOP_DIVU, 32'd9, 32'd2, 0, 0);
        wait_idle();

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                do_clr();
            end else begin
                if ($urandom_range(0, 3) != 0) wait_idle();
                drive(4'($urandom_range(0, 10)), pick(), pick(),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            end
        end

        wait_idle();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
